hazard_ctrl: RTL

Central pipeline controller for the five-stage CPU. It generates PC/IF-ID write enables, per-stage flush and bubble strobes, the global freeze for data-memory wait states, and ALU operand forwarding selects. It also keeps saturating stall and flush performance counters. It sits beside the IF/ID, ID/EX, EX/M and M/WB registers and drives their hold and clear controls.

---
 rtl/hazard_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze strobes, operand forwarding
// selects, memory wait-state timeout and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             Resetn,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic [4:0]       Rs_EX,
    input  logic [4:0]       Rt_EX,
    input  logic [4:0]       Rd_EX,
    input  logic             RegWr_EX,
    input  logic             MemtoReg_EX,
    input  logic [4:0]       Rd_M,
    input  logic             RegWr_M,
    input  logic [4:0]       Rd_WB,
    input  logic             RegWr_WB,
    input  logic             Branch_M,
    input  logic             Zero_M,
    input  logic             Jump_M,
    input  logic             MemWr_M,
    input  logic             MemtoReg_M,
    input  logic             MemReady,
    input  logic             CntClr,
    output logic             PCWr,
    output logic             IFID_Wr,
    output logic             PCSrc,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_M,
    output logic             Bubble_E,
    output logic             Freeze,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    localparam logic [3:0]       WAIT_MAX_C = 4'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    // The M-stage result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       regwr_m,
        input logic [4:0] rd_m,
        input logic       regwr_wb,
        input logic [4:0] rd_wb
    );
        logic [1:0] sel;
        if (regwr_m && (rd_m != 5'd0) && (rd_m == src)) begin
            sel = 2'b01;
        end else if (regwr_wb && (rd_wb != 5'd0) && (rd_wb == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [3:0]       wcnt_r;
    logic [3:0]       wcnt_s;
    logic             abandon_r;
    logic             abandon_s;
    logic             err_set_s;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic             memreq_s;
    logic             taken_s;
    logic             loaduse_s;
    logic             timeout_s;
    logic             freeze_s;
    logic             redirect_s;
    logic             pc_wr_s;
    logic             ifid_wr_s;
    logic             pc_src_s;
    logic             flush_s;
    logic             bubble_s;
    logic             stall_inc_s;

    assign memreq_s  = MemWr_M | MemtoReg_M;
    assign taken_s   = (Branch_M & Zero_M) | Jump_M;
    assign loaduse_s = MemtoReg_EX & RegWr_EX & (Rd_EX != 5'd0) &
                       ((Rd_EX == Rs_ID) | (Rd_EX == Rt_ID));
    assign timeout_s = (state_r == ST_MWAIT) & memreq_s & ~MemReady &
                       (wcnt_r == WAIT_MAX_C);
    // abandon_r keeps the timed-out access from re-freezing on the cycle after.
    assign freeze_s  = memreq_s & ~MemReady & ~timeout_s & ~abandon_r;
    assign redirect_s = ~freeze_s & taken_s;

    // Strobe priority: freeze, then redirect, then load-use stall.
    always_comb begin
        pc_wr_s   = 1'b1;
        ifid_wr_s = 1'b1;
        pc_src_s  = 1'b0;
        flush_s   = 1'b0;
        bubble_s  = 1'b0;
        if (freeze_s) begin
            pc_wr_s   = 1'b0;
            ifid_wr_s = 1'b0;
        end else if (taken_s) begin
            pc_src_s  = 1'b1;
            flush_s   = 1'b1;
        end else if (loaduse_s) begin
            pc_wr_s   = 1'b0;
            ifid_wr_s = 1'b0;
            bubble_s  = 1'b1;
        end else begin
            pc_wr_s   = 1'b1;
            ifid_wr_s = 1'b1;
        end
    end

    // Wait-state FSM next-state and wait counter.
    always_comb begin
        state_s   = state_r;
        wcnt_s    = wcnt_r;
        abandon_s = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    state_s = ST_MWAIT;
                    wcnt_s  = 4'd1;
                end else begin
                    state_s = ST_RUN;
                    wcnt_s  = 4'd0;
                end
            end
            ST_MWAIT: begin
                if (MemReady || !memreq_s) begin
                    state_s = ST_RUN;
                    wcnt_s  = 4'd0;
                end else if (timeout_s) begin
                    state_s   = ST_RUN;
                    wcnt_s    = 4'd0;
                    abandon_s = 1'b1;
                    err_set_s = 1'b1;
                end else begin
                    state_s = ST_MWAIT;
                    wcnt_s  = wcnt_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_RUN;
                wcnt_s  = 4'd0;
            end
        endcase
    end

    // FSM state, wait counter and abandon flag, on the pipeline's falling edge.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_r   <= ST_RUN;
            wcnt_r    <= 4'd0;
            abandon_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            wcnt_r    <= wcnt_s;
            abandon_r <= abandon_s;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            mem_err_r <= 1'b0;
        end else if (err_set_s) begin
            mem_err_r <= 1'b1;
        end
    end

    assign stall_inc_s = freeze_s | ~pc_wr_s;

    // Saturating performance counters; clear beats increment.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else if (CntClr) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_inc_s && (stall_cnt_r != CNT_MAX_C)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
            end
            if (redirect_s && (flush_cnt_r != CNT_MAX_C)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
            end
        end
    end

    assign PCWr     = pc_wr_s;
    assign IFID_Wr  = ifid_wr_s;
    assign PCSrc    = pc_src_s;
    assign Flush_D  = flush_s;
    assign Flush_E  = flush_s;
    assign Flush_M  = flush_s;
    assign Bubble_E = bubble_s;
    assign Freeze   = freeze_s;
    assign ForwardA = fwd_sel(Rs_EX, RegWr_M, Rd_M, RegWr_WB, Rd_WB);
    assign ForwardB = fwd_sel(Rt_EX, RegWr_M, Rd_M, RegWr_WB, Rd_WB);
    assign MemErr   = mem_err_r;
    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;

endmodule
